// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_pkg
//  Description : Shared definitions for the bit-serial adder: controller
//                state encoding, the state type and the counter-width
//                helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

   // Controller state encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } state_e;

   // The bit counter must be able to hold the value WIDTH itself,
   // so that it never wraps within an operation.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/serial_fa_bit.sv
`default_nettype none
// ============================================================================
//  Module      : serial_fa_bit
//  Description : Combinational one-bit full adder, the single arithmetic
//                slice shared by every bit position of the serial adder.
//  Ports       : a, b  - addend bits
//                cin   - carry in
//                s     - sum bit
//                cout  - carry out
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_fa_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic half_d;

   assign half_d = a ^ b;
   assign s      = half_d ^ cin;
   assign cout   = (a & b) | (cin & half_d);

endmodule : serial_fa_bit
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial adder. Adds two WIDTH-bit operands LSB-first,
//                one bit per clock, through a single full-adder slice and a
//                carry flop. Start/busy/done handshake; the result holds
//                until the next completion.
//  Ports       : clk, rst_n         - clock, async active-low reset
//                start              - begin an addition (IDLE or DONE only)
//                a, b, carryin      - operands, captured on accepted start
//                busy               - addition in progress
//                done               - one-cycle pulse when result valid
//                sum                - WIDTH-bit result
//                carryout, overflow - unsigned carry, signed overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carryin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carryout,
   output logic             overflow
);

   localparam int            CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_e           state_q;
   logic [WIDTH-1:0] sha_q;
   logic [WIDTH-1:0] shb_q;
   logic [WIDTH-1:0] shs_q;
   logic [WIDTH-1:0] shs_d;
   logic [WIDTH-1:0] sum_q;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   logic             c_q;
   logic             carry_q;
   logic             ovf_q;
   logic             busy_q;
   logic             done_q;
   logic             fa_s;
   logic             fa_cout;

   serial_fa_bit u_fa (
      .a    (sha_q[0]),
      .b    (shb_q[0]),
      .cin  (c_q),
      .s    (fa_s),
      .cout (fa_cout)
   );

   // New sum bit enters at the MSB; after WIDTH shifts the register holds
   // the complete result. Written with shifts so WIDTH=1 needs no slicing.
   assign shs_d = (shs_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
   assign cnt_d = cnt_q + CW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sha_q   <= '0;
         shb_q   <= '0;
         shs_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  sha_q   <= a;
                  shb_q   <= b;
                  shs_q   <= '0;
                  c_q     <= carryin;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_RUN: begin
               sha_q <= sha_q >> 1;
               shb_q <= shb_q >> 1;
               shs_q <= shs_d;
               c_q   <= fa_cout;
               cnt_q <= cnt_d;
               if (cnt_q == CNT_LAST) begin
                  // This edge processes the MSB: c_q is the carry into the
                  // MSB slice, fa_cout the carry out of it.
                  sum_q   <= shs_d;
                  carry_q <= fa_cout;
                  ovf_q   <= c_q ^ fa_cout;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign sum      = sum_q;
   assign carryout = carry_q;
   assign overflow = ovf_q;

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder (WIDTH=8). Directed
//                vectors push expected results into a scoreboard queue; an
//                independent monitor pops and compares on every done pulse,
//                including the cycle in which done is expected.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] sum;
      logic         co;
      logic         ov;
      int           cyc;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         carryin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         carryout;
   logic         overflow;

   exp_t         sb[$];
   int           cyc;
   int           n_pass;
   int           n_total;
   logic [W-1:0] prev_sum;

   serial_adder #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a        (a),
      .b        (b),
      .carryin  (carryin),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .carryout (carryout),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("done_unexpected", {31'b0, done}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sum",      {24'b0, sum},          {24'b0, e.sum});
            chk("carryout", {31'b0, carryout},     {31'b0, e.co});
            chk("overflow", {31'b0, overflow},     {31'b0, e.ov});
            chk("latency",  cyc,                   e.cyc);
         end
      end
   end

   task automatic push_exp(input logic [W-1:0] es, input logic eco, input logic eov);
      exp_t e;
      e.sum = es;
      e.co  = eco;
      e.ov  = eov;
      e.cyc = cyc + 1 + W;   // start set now, accepted next edge, done W edges later
      sb.push_back(e);
   endtask

   task automatic run(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                      input logic [W-1:0] es, input logic eco, input logic eov);
      int nb;
      @(negedge clk);
      start = 1'b1; a = ta; b = tb_v; carryin = tc;
      push_exp(es, eco, eov);
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); carryin = 1'b1;
      chk("sum_hold_in_run", {24'b0, sum}, {24'b0, prev_sum});
      nb = 0;
      repeat (W + 2) begin
         if (busy) nb++;
         @(negedge clk);
      end
      chk("busy_cycles", nb, W);
      prev_sum = es;
   endtask

   initial begin
      n_pass = 0; n_total = 0; prev_sum = '0;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; carryin = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy",     {31'b0, busy},     32'd0);
      chk("rst_done",     {31'b0, done},     32'd0);
      chk("rst_sum",      {24'b0, sum},      32'd0);
      chk("rst_carryout", {31'b0, carryout}, 32'd0);
      chk("rst_overflow", {31'b0, overflow}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      run(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      run(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      run(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
      run(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

      // start held through a whole run with operands churning, then a
      // second start landing in the DONE cycle.
      @(negedge clk);
      start = 1'b1; a = 8'h10; b = 8'h20; carryin = 1'b0;
      push_exp(8'h30, 1'b0, 1'b0);
      repeat (W) begin
         @(negedge clk);
         a = W'($urandom); b = W'($urandom); carryin = 1'b1;
      end
      @(negedge clk);
      chk("done_cycle_b2b", {31'b0, done}, 32'd1);
      a = 8'h12; b = 8'h34; carryin = 1'b0;
      push_exp(8'h46, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_b2b", {31'b0, busy}, 32'd1);
      repeat (W + 2) @(negedge clk);
      prev_sum = 8'h46;

      // Reset asserted for one cycle at the 4th RUN edge: aborts silently.
      @(negedge clk);
      start = 1'b1; a = 8'hAA; b = 8'h55; carryin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_busy",     {31'b0, busy},     32'd0);
      chk("abort_sum",      {24'b0, sum},      32'd0);
      chk("abort_carryout", {31'b0, carryout}, 32'd0);
      chk("abort_overflow", {31'b0, overflow}, 32'd0);
      rst_n = 1'b1;
      prev_sum = '0;
      repeat (W + 4) @(negedge clk);
      chk("abort_sum_later", {24'b0, sum}, 32'd0);

      run(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
      run(8'hC0, 8'h3F, 1'b1, 8'h00, 1'b1, 1'b0);

      for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_serial_adder
`default_nettype wire
